// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file sizing and the dump sequencer state type.
package regfile_pkg;
  localparam int DATA_W = 16;
  localparam int SEL_W = 4;
  localparam int REG_COUNT = 1 << SEL_W;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, CSUM} dump_state_t;
endpackage

// File: rtl/regfile_dump_fifo.sv
// regfile_dump_fifo: 2-entry shift FIFO for packed {data, index, last} words; head is always entry 0.
module regfile_dump_fifo #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] in_word,
  output logic [W-1:0] out_word,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] r_e0, r_e1;
  logic [1:0]   r_cnt;
  assign out_word = r_e0;
  assign full = r_cnt == 2'd2;
  assign empty = r_cnt == 2'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e0 <= '0;
      r_e1 <= '0;
      r_cnt <= 2'd0;
    end else if (push && pop) begin
      if (full) begin
        r_e0 <= r_e1;
        r_e1 <= in_word;
      end else r_e0 <= in_word;
    end else if (push) begin
      if (empty) r_e0 <= in_word;
      else r_e1 <= in_word;
      r_cnt <= r_cnt + 2'd1;
    end else if (pop) begin
      r_e0 <= r_e1;
      r_cnt <= r_cnt - 2'd1;
    end
  end
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: walks rf_select over a wrapping register range and streams the words out on valid/ready.
// Define REGFILE_DUMP_CSUM_EN to append a modulo-2^16 checksum word after the data.
module regfile_dump #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int SEL_W = regfile_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  first_reg,
  input  logic [SEL_W-1:0]  last_reg,
  output logic [SEL_W-1:0]  rf_select,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_index,
  output logic              out_last,
  output logic              out_csum,
  output logic              busy,
  output logic              done
);
  import regfile_pkg::*;
  localparam int W = DATA_W + SEL_W + 1;
  dump_state_t      r_state;
  logic [SEL_W-1:0] r_sel, r_rem;
  logic             r_pend, r_busy, r_done;
  logic             w_full, w_empty, w_pop, w_push, w_space, w_issue;
  logic [W-1:0]     w_in, w_out;
  assign rf_select = r_sel;
  assign busy = r_busy;
  assign done = r_done;
  assign out_valid = !w_empty;
  assign {out_data, out_index, out_last} = w_out;
  assign w_pop = out_valid && out_ready;
  // r_pend marks a select whose data lands in the FIFO at the next edge; only issue if that cannot overflow
  assign w_space = w_pop ? !(w_full && r_pend) : (w_empty || (!w_full && !r_pend));
  assign w_issue = (r_state == READ) && (r_rem != '0) && w_space;
`ifdef REGFILE_DUMP_CSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              w_csum_push;
  assign w_csum_push = (r_state == DRAIN) && (!w_full || w_pop);
  assign w_push = r_pend || w_csum_push;
  assign w_in = r_pend ? {rf_data, r_sel, 1'b0} : {r_sum, {SEL_W{1'b0}}, 1'b1};
  assign out_csum = out_valid && out_last;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sum <= '0;
    else if (r_state == IDLE) r_sum <= '0;
    else if (r_pend) r_sum <= r_sum + rf_data;
  end
`else
  assign w_push = r_pend;
  assign w_in = {rf_data, r_sel, r_rem == '0};
  assign out_csum = 1'b0;
`endif
  regfile_dump_fifo #(.W(W)) u_fifo (
    .clk(clk), .reset(reset), .push(w_push), .pop(w_pop),
    .in_word(w_in), .out_word(w_out), .full(w_full), .empty(w_empty)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel <= '0;
      r_rem <= '0;
      r_pend <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_pop && out_last;
      r_pend <= w_issue;
      case (r_state)
        IDLE: if (start) begin
          r_state <= READ;
          r_sel <= first_reg;
          r_rem <= last_reg - first_reg;
          r_pend <= 1'b1;
          r_busy <= 1'b1;
        end
        READ: if (w_issue) begin
          r_sel <= r_sel + SEL_W'(1);
          r_rem <= r_rem - SEL_W'(1);
        end else if (r_rem == '0) r_state <= DRAIN;
`ifdef REGFILE_DUMP_CSUM_EN
        DRAIN: if (w_csum_push) r_state <= CSUM;
`endif
        default: ;
      endcase
      if (w_pop && out_last) begin
        r_state <= IDLE;
        r_busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized scoreboard bench; a register-array model predicts every streamed word.
module tb_regfile_dump;
`ifdef REGFILE_DUMP_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  typedef struct {
    logic [15:0] d;
    logic [3:0]  i;
    logic        l;
    logic        c;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [3:0]  first_reg = '0, last_reg = '0, rf_select, out_index;
  logic [15:0] rf_data, out_data;
  logic        out_valid, out_last, out_csum, busy, done;
  logic [15:0] mem [16];
  exp_t        sb [$];
  int          checks = 0, passes = 0, xfers = 0, ready_mode = 0;
  bit          exp_done = 1'b0;
  always #5 clk = ~clk;
  assign rf_data = mem[rf_select];
  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rf_select(rf_select), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .out_csum(out_csum),
    .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic model(input logic [3:0] f, input logic [3:0] l);
    int n;
    logic [15:0] sum;
    logic [3:0] idx;
    n = ((int'(l) - int'(f) + 16) % 16) + 1;
    sum = '0;
    for (int k = 0; k < n; k++) begin
      idx = 4'((int'(f) + k) % 16);
      sum = sum + mem[idx];
      sb.push_back('{mem[idx], idx, !CSUM && (k == n - 1), 1'b0});
    end
    if (CSUM) sb.push_back('{sum, 4'd0, 1'b1, 1'b1});
  endtask
  task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input bit ign);
    int k, n;
    bit got;
    n = ((int'(l) - int'(f) + 16) % 16) + 1;
    @(posedge clk);
    #1 start = 1'b1;
    first_reg = f;
    last_reg = l;
    model(f, l);
    @(posedge clk);
    #1;
    if (ign) begin
      first_reg = 4'd0;
      last_reg = 4'd15;
    end else start = 1'b0;
    k = 0;
    got = 1'b0;
    repeat (400) begin
      @(negedge clk);
      k++;
      if (k == 2) start = 1'b0;
      if (ready_mode == 0 && k == 1) chk("issue", {busy, rf_select, out_valid}, {1'b1, f, 1'b0});
      if (ready_mode == 0 && k == 2) chk("first_valid", out_valid, 1);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (ready_mode == 0) chk("done_cycle", k, n + 2 + int'(CSUM));
    chk("all_words_out", sb.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1 out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? !out_ready : 1'($urandom_range(0, 1));
  end
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("done", done, exp_done);
      exp_done = 1'b0;
      if (done) chk("busy_low_at_done", busy, 0);
      if (out_valid) begin
        if (sb.size() == 0) chk("extra_word", out_valid, 0);
        else begin
          chk("word", {out_data, out_index, out_last, out_csum}, {sb[0].d, sb[0].i, sb[0].l, sb[0].c});
          if (out_ready) begin
            exp_done = sb[0].l;
            void'(sb.pop_front());
            xfers++;
          end
        end
      end
    end
  end
  initial begin
    int base;
    bit got;
    for (int i = 0; i < 16; i++) mem[i] = 16'(16 * (i + 1));
    #3 chk("reset_outputs", {rf_select, out_valid, out_data, out_index, out_last, out_csum, busy, done}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_dump(4'd0, 4'd15, 1'b0);
    run_dump(4'd14, 4'd1, 1'b0);
    run_dump(4'd0, 4'd3, 1'b0);
    ready_mode = 1;
    run_dump(4'd3, 4'd5, 1'b0);
    ready_mode = 0;
    run_dump(4'd7, 4'd7, 1'b1);
    repeat (20) @(negedge clk);
    chk("no_second_dump", {busy, out_valid}, 0);
    @(posedge clk);
    #1 start = 1'b1;
    first_reg = 4'd0;
    last_reg = 4'd15;
    model(4'd0, 4'd15);
    @(posedge clk);
    #1 start = 1'b0;
    base = xfers;
    got = 1'b0;
    repeat (100) begin
      @(posedge clk);
      if (xfers >= base + 4) begin
        got = 1'b1;
        break;
      end
    end
    chk("four_xfers", got, 1);
    #1 reset = 1'b1;
    sb.delete();
    exp_done = 1'b0;
    #1 chk("mid_reset_outputs", {rf_select, out_valid, out_data, out_index, out_last, out_csum, busy, done}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", {busy, out_valid, done}, 0);
    run_dump(4'd0, 4'd0, 1'b0);
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      ready_mode = $urandom_range(0, 2);
      run_dump(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
